// File: rtl/muldiv_pkg.sv
// muldiv_pkg: func codes, FSM states and op types shared by the mult/div sequencer
package muldiv_pkg;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    // encoding mirrors func[1:0]: bit 1 selects divide, bit 0 selects unsigned
    typedef enum logic [1:0] {OP_MULS = 2'b00, OP_MULU = 2'b01, OP_DIVS = 2'b10, OP_DIVU = 2'b11} op_t;
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction
    function automatic logic is_div(input op_t o);
        return o[1];
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: decode/regfile side of the mult/div sequencer
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hilo_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (
        output start, func, rs_val, rt_val, hilo_req,
        input  busy, stall, done, div_by_zero, hi, lo
    );
    modport slave (
        input  start, func, rs_val, rt_val, hilo_req,
        output busy, stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration over the {hi,lo} accumulator
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t                  op,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opb,
    output logic [2*WIDTH-1:0]   acc_nx
);
    logic [WIDTH:0] sum, rem, diff;
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        // remainder after the left shift, kept one bit wider so the trial subtract cannot overflow
        rem = acc[2*WIDTH-1:WIDTH-1];
        diff = rem - {1'b0, opb};
        acc_nx = is_div(op)
            ? (diff[WIDTH] ? {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
            : (acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO
// and stalling decode while an op is in flight
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst_b,
    muldiv_if.slave m
);
    localparam int CW = $clog2(WIDTH);
    state_t             state, state_nx;
    op_t                op;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, done_q, dbz_q, busy;
    logic               accept, dz, go, sgn, a_neg, b_neg;
    logic [2*WIDTH-1:0] acc, acc_nx, res;
    logic [WIDTH-1:0]   a_mag, b_mag, opb, hi, lo;
    muldiv_step #(.WIDTH(WIDTH)) u_step (.op(op), .acc(acc), .opb(opb), .acc_nx(acc_nx));
    always_comb begin
        accept = state == IDLE && m.start && is_muldiv(m.func);
        sgn = !m.func[0];
        dz = accept && m.func[1] && m.rt_val == '0;
        go = accept && !dz;
        a_neg = sgn && m.rs_val[WIDTH-1];
        b_neg = sgn && m.rt_val[WIDTH-1];
        a_mag = a_neg ? -m.rs_val : m.rs_val;
        b_mag = b_neg ? -m.rt_val : m.rt_val;
        // quotient takes the xor of signs, remainder follows the dividend
        res = is_div(op)
            ? {neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH], neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]}
            : (neg_q ? -acc : acc);
        state_nx = state == IDLE ? (go ? ITER : IDLE) : state == ITER ? (cnt == '0 ? FIX : ITER) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op <= OP_MULS;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            acc <= '0;
            opb <= '0;
            hi <= '0;
            lo <= '0;
            done_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            done_q <= state == FIX || dz;
            dbz_q <= dz;
            if (go) begin
                op <= op_t'(m.func[1:0]);
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                acc <= {{WIDTH{1'b0}}, m.func[1] ? a_mag : b_mag};
                opb <= m.func[1] ? b_mag : a_mag;
                cnt <= CW'(WIDTH - 1);
            end else if (state == ITER) begin
                acc <= acc_nx;
                cnt <= cnt - 1'b1;
            end
            if (state == FIX) begin
                hi <= res[2*WIDTH-1:WIDTH];
                lo <= res[WIDTH-1:0];
            end
        end
    end
    assign busy = state != IDLE;
    assign m.busy = busy;
    assign m.stall = busy && (m.hilo_req || m.start);
    assign m.done = done_q;
    assign m.div_by_zero = dbz_q;
    assign m.hi = hi;
    assign m.lo = lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for mult/div results, latency, stall and reset
module tb_muldiv_sequencer;
    import muldiv_pkg::*;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int errors = 0;
    int checks = 0;
    int n;
    int stall_cnt;
    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst_b(rst_b), .m(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        bus.start = 1'b1;
        bus.func = f;
        bus.rs_val = a;
        bus.rt_val = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd34);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.func = '0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.hilo_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_b = 1'b1;
        @(negedge clk);
        run_op(F_MULT, 32'd7, 32'hFFFF_FFFD, "mult_neg");
        check("mult_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'd0);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'd16, "divu");
        check("divu_hilo", {bus.hi, bus.lo}, 64'h0000_000F_0FFF_FFFF);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
        check("div_wrap_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(F_DIVU, 32'h5678_1234, 32'h0001_0000, "divu_prep");
        check("divu_prep_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);
        bus.start = 1'b1;
        bus.func = F_DIV;
        bus.rs_val = 32'd99;
        bus.rt_val = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("dz_flag", 64'(bus.div_by_zero), 64'd1);
        check("dz_done", 64'(bus.done), 64'd1);
        check("dz_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("dz_pulse", {62'd0, bus.div_by_zero, bus.done}, 64'd0);
        check("dz_hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);
        bus.start = 1'b1;
        bus.func = F_MFHI;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored_func", {62'd0, bus.busy, bus.done}, 64'd0);
        bus.start = 1'b1;
        bus.func = F_MULT;
        bus.rs_val = 32'd2;
        bus.rt_val = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        stall_cnt = 0;
        for (int c = 1; c <= 34; c++) begin
            if (c == 5) bus.hilo_req = 1'b1;
            if (c == 10) begin
                bus.start = 1'b1;
                bus.func = F_MULTU;
                bus.rs_val = 32'd3;
                bus.rt_val = 32'd5;
            end
            #1;
            if (c == 4) check("stall_before_req", 64'(bus.stall), 64'd0);
            if (c >= 5 && c <= 33 && bus.stall) stall_cnt++;
            if (c == 34) begin
                check("stall_cycles", 64'(stall_cnt), 64'd29);
                check("stall_done_cycle", 64'(bus.stall), 64'd0);
                check("stall_first_done", 64'(bus.done), 64'd1);
                check("stall_first_hilo", {bus.hi, bus.lo}, 64'd6);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.hilo_req = 1'b0;
        n = 35;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("held_start_done_cycle", 64'(n), 64'd68);
        check("held_start_done", 64'(bus.done), 64'd1);
        check("held_start_hilo", {bus.hi, bus.lo}, 64'd15);
        bus.start = 1'b1;
        bus.func = F_DIV;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst_b = 1'b0;
        #1;
        check("mid_reset_busy", 64'(bus.busy), 64'd0);
        check("mid_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'(bus.busy), 64'd0);
        run_op(F_MULT, 32'd3, 32'd4, "post_reset_mult");
        check("post_reset_hilo", {bus.hi, bus.lo}, 64'd12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU R-type ops that the single-cycle control decoder passes through as func codes. It owns the HI/LO registers and runs an iterative shift-add multiplier or restoring divider over 32 iterations. While a HI/LO consumer or a second mult/div arrives during an operation, it stalls the pipeline. It sits beside the ALU and is fed from decode (func, start) and the register file (rs, rt).

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge
rst_b  in  1  asynchronous active-low reset
start  in  1  decode issues an op with opcode 000000 and a mult/div func
func  in  6  instruction func field, sampled on accept
rs_val  in  WIDTH  operand A (multiplicand / dividend)
rt_val  in  WIDTH  operand B (multiplier / divisor)
hilo_req  in  1  decode holds an MFHI/MFLO this cycle
busy  out  1  operation in progress
stall  out  1  freeze PC and IF/ID
done  out  1  one-cycle pulse after HI/LO update
div_by_zero  out  1  one-cycle pulse, DIV/DIVU with rt_val==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_b=0): state IDLE, hi=lo=0, busy=stall=done=div_by_zero=0, internal accumulators cleared. Reset mid-operation aborts the op; HI/LO read 0 afterwards.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 with func in {011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU} is accepted on the clock edge.
  - Other func values with start=1 are ignored and stay IDLE.
- Accept:
  - Latch op type and signedness.
  - Signed ops: latch |rs|, |rt| plus sign flags. Unsigned ops: latch raw operands.
  - Load iteration counter = WIDTH-1, go to ITER.
- DIV/DIVU with rt_val==0:
  - Do not enter ITER; HI/LO unchanged.
  - div_by_zero=1 and done=1 in the cycle after accept; stay IDLE.
- ITER, one step per clock:
  - Multiply: test multiplier LSB, add multiplicand into upper half of the 2*WIDTH product, shift right 1.
  - Divide: shift remainder:quotient left 1, trial-subtract divisor; if non-negative keep it and set quotient LSB.
  - Counter==0 -> FIX, else decrement.
- FIX (one cycle), sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write hi (product high / remainder) and lo (product low / quotient) on the FIX->IDLE edge.
- Latency: accept at edge 0, 32 ITER edges, FIX write at edge 33; done=1 during cycle 34. HI/LO hold the new values from cycle 34.
- busy = (state != IDLE).
- stall = busy & (hilo_req | start).
- start while busy is ignored; decode must hold it under stall and it is accepted on the first IDLE cycle.
- hilo_req and start in the done cycle: no stall, new HI/LO visible.
- Unsigned magnitudes use WIDTH+1-bit arithmetic internally.
- Signed edge case: -2^31 / -1 gives lo=0x80000000, hi=0 (wrap, no trap).
- done and div_by_zero are registered and never overlap except on a divide-by-zero.

Decomposition:
- Shared package muldiv_pkg holds:
  - func constants: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MFLO 010010.
  - State encoding: IDLE/ITER/FIX.
  - Op-type enum: MUL/DIV, signed/unsigned.
- One natural sub-module, muldiv_step: a combinational single iteration (shift-add or restore-subtract) selected by op type. The sequencer holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) -> busy cycles 1-33, done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFFF/16 -> lo=0x0FFFFFFF, hi=0xF.
- DIV rt=0 with prior hi=0x1234, lo=0x5678 -> div_by_zero=1 and done=1 in cycle 1, busy never set, hi/lo unchanged.
- hilo_req=1 at cycle 5 of a MULT -> stall=1 through cycle 33, 0 at cycle 34. A second start at cycle 10, held under stall -> accepted at cycle 34, done at cycle 68.
- rst_b low at cycle 15 of a DIV -> busy=0, hi=lo=0 immediately. After release, MULT 3*4 -> lo=12, hi=0.
